// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: non-stalling FIFO for the CPU write-back trace, drained by a valid/ready consumer.
// Ports: clk/reset (sync, active-high); debug_wb_* trace input; trace_valid/trace_ready
// handshake with FWFT head fields trace_pc/wen/wnum/wdata; count occupancy; overflow and
// drop_cnt loss tracking, cleared by clear_ovf. Define WB_TRACE_R0_FILTER_EN to ignore r0 writes.
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   debug_wb_pc,
  input  logic [3:0]    debug_wb_rf_wen,
  input  logic [4:0]    debug_wb_rf_wnum,
  input  logic [31:0]   debug_wb_rf_wdata,
  output logic          trace_valid,
  input  logic          trace_ready,
  output logic [31:0]   trace_pc,
  output logic [3:0]    trace_wen,
  output logic [4:0]    trace_wnum,
  output logic [31:0]   trace_wdata,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [15:0]   drop_cnt,
  input  logic          clear_ovf
);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  logic [72:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic cand, pop, push, drop;
`ifdef WB_TRACE_R0_FILTER_EN
  assign cand = |debug_wb_rf_wen && |debug_wb_rf_wnum;
`else
  assign cand = |debug_wb_rf_wen;
`endif
  assign trace_valid = count != '0;
  assign pop = trace_valid && trace_ready;
  // a pop at full frees the slot the push lands in
  assign push = cand && (count != FULL || pop);
  assign drop = cand && !push;
  assign {trace_pc, trace_wen, trace_wnum, trace_wdata} = mem[rp];
  always_ff @(posedge clk)
    if (!reset && push)
      mem[wp] <= {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
      overflow <= clear_ovf ? 1'b0 : overflow | drop;
      drop_cnt <= clear_ovf ? '0 : (drop && drop_cnt != 16'hFFFF) ? drop_cnt + 1'b1 : drop_cnt;
    end
  end
endmodule

// File: tb/tb_wb_trace_fifo.sv
// tb_wb_trace_fifo: randomized and directed checks of wb_trace_fifo against a queue model.
module tb_wb_trace_fifo;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] pc = '0, wdata = '0;
  logic [3:0] wen = '0;
  logic [4:0] wnum = '0;
  logic ready = 1'b0, clr = 1'b0;
  logic trace_valid, overflow;
  logic [31:0] trace_pc, trace_wdata;
  logic [3:0] trace_wen;
  logic [4:0] trace_wnum;
  logic [4:0] count;
  logic [15:0] drop_cnt;
  logic [72:0] q[$];
  logic m_ovf;
  int m_drop;
  int checks = 0, failures = 0;

  wb_trace_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
    .clk(clk), .reset(reset),
    .debug_wb_pc(pc), .debug_wb_rf_wen(wen), .debug_wb_rf_wnum(wnum), .debug_wb_rf_wdata(wdata),
    .trace_valid(trace_valid), .trace_ready(ready),
    .trace_pc(trace_pc), .trace_wen(trace_wen), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .clear_ovf(clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic compare();
    chk("count", 73'(count), 73'(q.size()));
    chk("valid", 73'(trace_valid), 73'(q.size() != 0));
    chk("overflow", 73'(overflow), 73'(m_ovf));
    chk("drop_cnt", 73'(drop_cnt), 73'(m_drop));
    if (q.size() != 0) chk("head", {trace_pc, trace_wen, trace_wnum, trace_wdata}, q[0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wen = 4'hF; wnum = 5'd3; ready = 1'b1; clr = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    q.delete(); m_ovf = 1'b0; m_drop = 0;
    compare();
  endtask

  task automatic cycle(input logic [31:0] p, input logic [3:0] e, input logic [4:0] n,
                       input logic [31:0] d, input logic r, input logic c);
    bit cand, pop, push;
    pc = p; wen = e; wnum = n; wdata = d; ready = r; clr = c;
`ifdef WB_TRACE_R0_FILTER_EN
    cand = e != 0 && n != 0;
`else
    cand = e != 0;
`endif
    pop = q.size() != 0 && r;
    push = cand && (q.size() < DEPTH || pop);
    if (pop) void'(q.pop_front());
    if (push) q.push_back({p, e, n, d});
    if (c) begin
      m_ovf = 1'b0; m_drop = 0;
    end else if (cand && !push) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop++;
    end
    @(posedge clk); #1;
    compare();
  endtask

  task automatic idle(input logic r);
    cycle($urandom, 4'h0, 5'($urandom), $urandom, r, 1'b0);
  endtask

  task automatic push_one(input logic [31:0] d, input logic r, input logic c);
    cycle($urandom, 4'($urandom_range(1, 15)), 5'($urandom_range(1, 31)), d, r, c);
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();
    // single push, then one pop
    cycle(32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678, 1'b0, 1'b0);
    chk("single_head", {trace_pc, trace_wen, trace_wnum, trace_wdata},
        {32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678});
    chk("single_count", 73'(count), 73'd1);
    idle(1'b1);
    chk("single_empty", 73'(trace_valid), 73'd0);
    // fill and overflow
    for (int i = 0; i < 20; i++) push_one(i, 1'b0, 1'b0);
    chk("fill_count", 73'(count), 73'd16);
    chk("fill_drop", 73'(drop_cnt), 73'd4);
    // full with simultaneous push and pop
    push_one(32'hCAFE_0001, 1'b1, 1'b0);
    chk("full_pp_count", 73'(count), 73'd16);
    chk("full_pp_drop", 73'(drop_cnt), 73'd4);
    for (int i = 0; i < 16; i++) idle(1'b1);
    // random interleave with stalls, wrap and occasional clear
    for (int i = 0; i < 400; i++)
      cycle($urandom, ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
            5'($urandom_range(0, 3) == 0 ? 0 : $urandom), $urandom,
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0));
    // clear versus drop in the same cycle
    for (int i = 0; i < 20; i++) push_one($urandom, 1'b0, 1'b0);
    push_one(32'hDEAD_BEEF, 1'b0, 1'b1);
    chk("clr_ovf", 73'(overflow), 73'd0);
    chk("clr_drop", 73'(drop_cnt), 73'd0);
    // drop counter saturation
    for (int i = 0; i < 65540; i++) push_one(i, 1'b0, 1'b0);
    chk("sat_drop", 73'(drop_cnt), 73'hFFFF);
    push_one(32'h1, 1'b0, 1'b0);
    chk("sat_hold", 73'(drop_cnt), 73'hFFFF);
    // mid-operation reset discards everything
    do_reset();
    for (int i = 0; i < 5; i++) push_one($urandom, 1'b0, 1'b0);
    do_reset();
    chk("rst_count", 73'(count), 73'd0);
    // r0 write handling
    cycle(32'h100, 4'hF, 5'd0, 32'h55, 1'b0, 1'b0);
`ifdef WB_TRACE_R0_FILTER_EN
    chk("r0_count", 73'(count), 73'd0);
`else
    chk("r0_count", 73'(count), 73'd1);
`endif
    chk("r0_drop", 73'(drop_cnt), 73'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wb_trace_fifo.md
# wb_trace_fifo

Buffers the CPU's per-cycle write-back trace (`debug_wb_pc`, `debug_wb_rf_wen`, `debug_wb_rf_wnum`, `debug_wb_rf_wdata`) from `mycpu_top` into a FIFO. The FIFO is drained through a valid/ready handshake by a slower consumer, such as a trace comparator, a UART dumper or an on-chip logic analyser. The CPU is never stalled by this block: when the FIFO is full, new entries are dropped, and the loss is recorded in a sticky flag and a counter.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, 2..256.
- `AW`, 4, pointer width; must equal log2(`DEPTH`).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `debug_wb_pc`  in  32  write-back PC from the CPU.
- `debug_wb_rf_wen`  in  4  byte write enables; nonzero means a valid write.
- `debug_wb_rf_wnum`  in  5  destination register number.
- `debug_wb_rf_wdata`  in  32  write data.
- `trace_valid`  out  1  head entry is available.
- `trace_ready`  in  1  consumer accepts the head entry.
- `trace_pc`  out  32  head entry PC.
- `trace_wen`  out  4  head entry write enables.
- `trace_wnum`  out  5  head entry register number.
- `trace_wdata`  out  32  head entry data.
- `count`  out  `AW`+1  current occupancy, 0..`DEPTH`.
- `overflow`  out  1  sticky flag: at least one entry was dropped.
- `drop_cnt`  out  16  number of dropped entries; saturates at 16'hFFFF.
- `clear_ovf`  in  1  one-cycle pulse that clears `overflow` and `drop_cnt`.

## Operation
- Candidate entry: `debug_wb_rf_wen != 0`, further qualified by the filter described in Configuration.
- pop: `trace_valid && trace_ready`.
- push: candidate && (`count < DEPTH` || pop).
  - At full, a simultaneous pop frees a slot, so the push is accepted.
- drop: candidate && !push.
  - On a drop, `overflow` is set to 1.
  - On a drop, `drop_cnt` increments unless it is already 16'hFFFF.
- Storage:
  - Circular array of `DEPTH` × 73 bits.
  - Write pointer `wp` and read pointer `rp`, each `AW` bits, wrapping naturally modulo `DEPTH`.
  - Occupancy is held in a separate register `count`; full and empty are never derived from pointer equality.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Output form is first-word-fall-through:
  - `trace_valid = (count != 0)`.
  - `trace_*` = array[`rp`], driven combinationally from the register array.
  - When `trace_valid` = 0, `trace_*` are don't-care.
- `clear_ovf`:
  - Clears `overflow` and `drop_cnt` in the cycle it is sampled.
  - If a drop occurs in the same cycle, clear wins: both end at 0.
  - FIFO contents are not touched.
- Handshake rule: the entry presented while `trace_valid` = 1 and `trace_ready` = 0 must remain stable until it is popped. Pushes never alter the head entry.

## Timing
- Reset values: `wp` = `rp` = 0, `count` = 0, `trace_valid` = 0, `overflow` = 0, `drop_cnt` = 0. The array is not reset.
- Push latency: a candidate sampled at edge N into an empty FIFO gives `trace_valid` = 1 and `trace_*` equal to that entry after edge N; it is visible in cycle N+1.
- Pop: `rp` advances at the edge where pop holds. The next entry is presented in the following cycle.
- Throughput: one push and one pop per cycle, sustained.
- Empty plus candidate plus `trace_ready` = 1: no pop in that cycle, because `trace_valid` = 0. There is no bypass path.
- `reset` asserted mid-operation: all contents are discarded and the next cycle shows the reset values. Inputs in the reset cycle are ignored.

## Configuration
- `WB_TRACE_R0_FILTER_EN` defined:
  - Candidate additionally requires `debug_wb_rf_wnum != 0`.
  - Writes to r0 are silently ignored: they are neither stored nor counted as drops.
- Not defined: writes to r0 with nonzero `wen` are recorded like any other write.

## Test plan
- Single push: after reset, one cycle of pc = 32'hBFC0_0000, wen = 4'hF, wnum = 5'd8, wdata = 32'h1234_5678, with `trace_ready` = 0 → the next cycle shows `trace_valid` = 1 with those exact values and `count` = 1. Raising `trace_ready` for one cycle → `count` = 0 and `trace_valid` = 0.
- Fill and overflow (DEPTH = 16): 20 consecutive candidates with wdata = 0..19 and `trace_ready` = 0 → `count` = 16, `overflow` = 1, `drop_cnt` = 4. Draining yields wdata 0..15 in order.
- Full with simultaneous push and pop: with the FIFO full, one candidate plus `trace_ready` = 1 → `count` stays 16, `drop_cnt` unchanged, the new entry appears last on drain.
- Stall stability and wrap: interleave 40 pushes with random `trace_ready` → every output matches a reference queue. Output is stable while `trace_ready` = 0, and order is correct across pointer wrap.
- Clear versus drop: full FIFO, `clear_ovf` = 1 in the same cycle as a dropped candidate → next cycle `overflow` = 0 and `drop_cnt` = 0. Separately, force `drop_cnt` to 16'hFFFF and drop again → it holds at 16'hFFFF.
- r0 filter: candidate with wnum = 0, wen = 4'hF → with `WB_TRACE_R0_FILTER_EN` defined, `count` stays 0 and `drop_cnt` stays 0; without it, `count` = 1.
